// File: rtl/cpu_exec.sv
// Mini-CPU execution stage: runs one instruction against a 16x16 register file,
// then holds opcode/result steady so the LCD driver can finish its write.
module cpu_exec #(
    parameter int DISP_HOLD = 1_200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_op,
    input  logic [3:0]  instr_dst,
    input  logic [3:0]  instr_src1,
    input  logic [3:0]  instr_src2,
    input  logic [15:0] instr_imm,
    output logic [2:0]  opcode,
    output logic [15:0] result,
    output logic        done
);

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    localparam int HW = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(DISP_HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_HOLD} state_t;

    state_t        state;
    logic [15:0]   rf [16];
    logic [2:0]    op_q;
    logic [3:0]    dst_q;
    logic [3:0]    src1_q;
    logic [3:0]    src2_q;
    logic [15:0]   imm_q;
    logic [15:0]   mcand;
    logic [15:0]   mplier;
    logic [15:0]   acc;
    logic [3:0]    mul_cnt;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   alu_res;
    logic [15:0]   mul_sum;

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = rf[src1_q] + rf[src2_q];
            OP_ADDI: alu_res = rf[src1_q] + imm_q;
            OP_SUB:  alu_res = rf[src1_q] - rf[src2_q];
            OP_SUBI: alu_res = rf[src1_q] - imm_q;
            default: alu_res = '0;
        endcase
        mul_sum = acc + (mplier[0] ? mcand : 16'd0);
    end

    // instr_ready is registered so it stays low for one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_ready <= 1'b0;
            opcode      <= OP_LOAD;
            result      <= '0;
            done        <= 1'b0;
            hold_cnt    <= '0;
            mul_cnt     <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            op_q        <= '0;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    instr_ready <= 1'b1;
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr_op;
                        dst_q       <= instr_dst;
                        src1_q      <= instr_src1;
                        src2_q      <= instr_src2;
                        imm_q       <= instr_imm;
                        instr_ready <= 1'b0;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    hold_cnt <= '0;
                    case (op_q)
                        OP_LOAD: begin
                            rf[dst_q]   <= imm_q;
                            result      <= imm_q;
                            opcode      <= OP_LOAD;
                            done        <= 1'b1;
                            instr_ready <= 1'b1;
                            state       <= S_IDLE;
                        end
                        OP_MUL: begin
                            mcand   <= rf[src1_q];
                            mplier  <= rf[src2_q];
                            acc     <= '0;
                            mul_cnt <= '0;
                            state   <= S_MUL;
                        end
                        OP_CLEAR: begin
                            for (int i = 0; i < 16; i++) rf[i] <= '0;
                            result <= '0;
                            opcode <= OP_CLEAR;
                            done   <= 1'b1;
                            state  <= S_HOLD;
                        end
                        OP_DISPLAY: begin
                            result <= rf[src1_q];
                            opcode <= OP_DISPLAY;
                            done   <= 1'b1;
                            state  <= S_HOLD;
                        end
                        default: begin
                            rf[dst_q] <= alu_res;
                            result    <= alu_res;
                            opcode    <= op_q;
                            done      <= 1'b1;
                            state     <= S_HOLD;
                        end
                    endcase
                end
                S_MUL: begin
                    acc     <= mul_sum;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + 4'd1;
                    if (mul_cnt == 4'd15) begin
                        rf[dst_q] <= mul_sum;
                        result    <= mul_sum;
                        opcode    <= OP_MUL;
                        done      <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt    <= '0;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec.sv
// Self-checking bench for cpu_exec: a register-file model predicts each commit,
// and a scoreboard checks opcode/result/timing whenever done pulses.
module tb_cpu_exec;

    localparam int DISP_HOLD = 4;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = '0;
    logic [3:0]  instr_dst = '0;
    logic [3:0]  instr_src1 = '0;
    logic [3:0]  instr_src2 = '0;
    logic [15:0] instr_imm = '0;
    logic [2:0]  opcode;
    logic [15:0] result;
    logic        done;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_rf [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    cpu_exec #(.DISP_HOLD(DISP_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_op   (instr_op),
        .instr_dst  (instr_dst),
        .instr_src1 (instr_src1),
        .instr_src2 (instr_src2),
        .instr_imm  (instr_imm),
        .opcode     (opcode),
        .result     (result),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each done pulse must match the oldest predicted commit, on its predicted cycle.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("opcode", 32'(opcode), 32'(e.op));
                checkOutput("result", 32'(result), 32'(e.res));
                checkOutput("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] dst,
                                 input logic [3:0] s1, input logic [3:0] s2,
                                 input logic [15:0] imm, input bit keep_valid);
        int          waited;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        exp_t        e;
        waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checkOutput("ready_timeout", 32'(instr_ready), 32'd1);
            return;
        end
        instr_op    = op;
        instr_dst   = dst;
        instr_src1  = s1;
        instr_src2  = s2;
        instr_imm   = imm;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) instr_valid = 1'b0;
        a = model_rf[s1];
        b = model_rf[s2];
        e.op  = op;
        e.due = cyc + ((op == OP_MUL) ? 17 : 1);
        case (op)
            OP_LOAD:  e.res = imm;
            OP_ADD:   e.res = a + b;
            OP_ADDI:  e.res = a + imm;
            OP_SUB:   e.res = a - b;
            OP_SUBI:  e.res = a - imm;
            OP_MUL: begin
                prod  = 32'(a) * 32'(b);
                e.res = prod[15:0];
            end
            OP_CLEAR: e.res = 16'd0;
            default:  e.res = a;
        endcase
        if (op == OP_CLEAR) begin
            for (int i = 0; i < 16; i++) model_rf[i] = 16'd0;
        end else if (op != OP_DISPLAY) begin
            model_rf[dst] = e.res;
        end
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int low_cnt;
        int extra_acc;
        int waited;
        for (int i = 0; i < 16; i++) model_rf[i] = 16'd0;

        // Reset held across several edges, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_opcode", 32'(opcode), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ready", 32'(instr_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(instr_ready), 32'd1);

        // LOAD has no hold: ready returns two cycles after the handshake.
        applyStimulus(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'd1234, 1'b0);
        @(negedge clk);
        checkOutput("load_exec_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        checkOutput("load_no_hold", 32'(instr_ready), 32'd1);

        // Wrap-around arithmetic.
        applyStimulus(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'd65535, 1'b0);
        applyStimulus(OP_LOAD, 4'd2, 4'd0, 4'd0, 16'd2, 1'b0);
        applyStimulus(OP_ADD,  4'd3, 4'd1, 4'd2, 16'd0, 1'b0);
        applyStimulus(OP_SUB,  4'd4, 4'd2, 4'd1, 16'd0, 1'b0);
        applyStimulus(OP_SUBI, 4'd5, 4'd2, 4'd0, 16'd5, 1'b0);

        // Multiply with truncation, then display the product.
        applyStimulus(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'd300, 1'b0);
        applyStimulus(OP_LOAD, 4'd2, 4'd0, 4'd0, 16'd250, 1'b0);
        applyStimulus(OP_MUL,  4'd3, 4'd1, 4'd2, 16'd0, 1'b0);
        applyStimulus(OP_DISPLAY, 4'd0, 4'd3, 4'd0, 16'd0, 1'b0);

        // dst == src1, with valid held high through the whole hold window.
        applyStimulus(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'd10, 1'b0);
        applyStimulus(OP_ADDI, 4'd1, 4'd1, 4'd0, 16'd7, 1'b1);
        @(negedge clk);
        checkOutput("addi_exec_ready", 32'(instr_ready), 32'd0);
        low_cnt   = 0;
        extra_acc = 0;
        for (int i = 0; i < DISP_HOLD; i++) begin
            @(negedge clk);
            if (!instr_ready) low_cnt++;
            if (instr_ready && instr_valid) extra_acc++;
        end
        @(negedge clk);
        checkOutput("hold_release_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b0;
        checkOutput("hold_low_cycles", 32'(low_cnt), 32'(DISP_HOLD));
        checkOutput("hold_extra_accept", 32'(extra_acc), 32'd0);
        applyStimulus(OP_DISPLAY, 4'd0, 4'd1, 4'd0, 16'd0, 1'b0);

        // CLEAR wipes every register.
        for (int i = 0; i < 16; i++)
            applyStimulus(OP_LOAD, 4'(i), 4'd0, 4'd0, 16'(i * 3 + 1), 1'b0);
        applyStimulus(OP_CLEAR, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0);
        applyStimulus(OP_DISPLAY, 4'd0, 4'd7, 4'd0, 16'd0, 1'b0);
        applyStimulus(OP_DISPLAY, 4'd0, 4'd15, 4'd0, 16'd0, 1'b0);

        // Reset on MUL cycle 8 abandons the multiply.
        applyStimulus(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'd3, 1'b0);
        applyStimulus(OP_LOAD, 4'd2, 4'd0, 4'd0, 16'd5, 1'b0);
        applyStimulus(OP_LOAD, 4'd3, 4'd0, 4'd0, 16'd77, 1'b0);
        applyStimulus(OP_DISPLAY, 4'd0, 4'd3, 4'd0, 16'd0, 1'b0);
        applyStimulus(OP_MUL, 4'd3, 4'd1, 4'd2, 16'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 16; i++) model_rf[i] = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midmul_rst_opcode", 32'(opcode), 32'd0);
        checkOutput("midmul_rst_result", 32'(result), 32'd0);
        checkOutput("midmul_rst_done", 32'(done), 32'd0);
        checkOutput("midmul_rst_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        checkOutput("midmul_ready_back", 32'(instr_ready), 32'd1);
        applyStimulus(OP_DISPLAY, 4'd0, 4'd3, 4'd0, 16'd0, 1'b0);

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_exec.md
# cpu_exec

Execution stage of the Mini-CPU, directly upstream of the character-LCD driver. It accepts one instruction at a time over a valid/ready handshake and executes it against a 16×16-bit register file. It presents the 3-bit opcode and 16-bit result that the LCD driver renders, then holds them stable long enough for the LCD driver to finish its write sequence before accepting the next instruction.

## Interface
- `DISP_HOLD`, default 1_200_000: cycles opcode/result are held after a displayed instruction (24 ms at 50 MHz); legal range ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction fields valid.
- `instr_ready`  out  1  high exactly when state is IDLE.
- `instr_op`  in  3  opcode: LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
- `instr_dst`  in  4  destination register index.
- `instr_src1`  in  4  first source register index.
- `instr_src2`  in  4  second source register index.
- `instr_imm`  in  16  immediate, unsigned.
- `opcode`  out  3  registered opcode to LCD driver.
- `result`  out  16  registered result to LCD driver.
- `done`  out  1  one-cycle pulse when `opcode`/`result` update.

## Operation
- States: IDLE, EXEC, MUL, HOLD.
- IDLE: `instr_ready`=1. On `instr_valid`, latch all fields → EXEC. Fields are ignored while not ready.
- EXEC (one cycle): sources are read from the register file before any write in the same cycle, so dst=src is legal.
  - LOAD: rf[dst]←imm, result←imm, opcode←LOAD → IDLE (no hold; the LCD driver ignores LOAD).
  - ADD: rf[dst]←rf[src1]+rf[src2]. ADDI: rf[src1]+imm. SUB: rf[src1]−rf[src2]. SUBI: rf[src1]−imm. All are modulo 2^16 (overflow/borrow discarded). Write rf[dst], result and opcode → HOLD.
  - MUL: load multiplicand=rf[src1], multiplier=rf[src2], acc=0, iteration count=0 → MUL.
  - CLEAR: all 16 registers←0, result←0, opcode←CLEAR → HOLD.
  - DISPLAY: result←rf[src1], opcode←DISPLAY, no register write → HOLD.
- MUL: shift-add, one multiplier bit per cycle (LSB first), exactly 16 cycles. Then rf[dst]←low 16 bits of the product, result←same, opcode←MUL → HOLD.
- HOLD: counter runs 0..DISP_HOLD−1, then → IDLE. `opcode`/`result` are frozen.
- Outside commit cycles, `opcode`/`result` retain their last value, including in IDLE.
- `done`=1 only in the cycle immediately after a commit edge.
- Reset values: `opcode`=000 (LOAD), `result`=0, `done`=0, all registers 0, state IDLE, HOLD counter 0.
- `rst` has priority in every state. Mid-MUL or mid-HOLD, the operation is abandoned with no register write, and outputs return to reset values on the next edge. `instr_ready`=0 during the reset cycle and 1 on the cycle after.

## Timing
- Handshake at cycle T (valid&ready sampled high) → EXEC at T+1.
- LOAD/ADD/ADDI/SUB/SUBI/CLEAR/DISPLAY: outputs visible and `done`=1 at T+2.
- MUL: EXEC at T+1, MUL at T+2..T+17; outputs visible and `done`=1 at T+18.
- Displayed ops: HOLD occupies DISP_HOLD cycles from the commit cycle; `instr_ready` rises DISP_HOLD cycles after the outputs appear (non-MUL: T+2+DISP_HOLD).
- LOAD: `instr_ready` high again at T+2. Back-to-back LOADs therefore accept every 2 cycles.
- Maximum throughput: one displayed instruction per 2+DISP_HOLD cycles; MUL adds 16.

## Test plan
- Run all tests with DISP_HOLD=4. Reset, then LOAD r1←1234 at T → T+2: `opcode`=000, `result`=1234, `done`=1, `instr_ready`=1; no HOLD.
- LOAD r1←65535, LOAD r2←2, ADD r3=r1+r2 → `result`=1, `opcode`=001; SUB r4=r2−r1 → `result`=3; SUBI r5=r2−5 → 65533.
- LOAD r1←300, LOAD r2←250, MUL r3 → `done` exactly 18 cycles after the handshake, `result`=9464 (75000 mod 65536); DISPLAY r3 → `result`=9464, `opcode`=111.
- ADDI r1=r1+7 with dst=src1 (r1=10) → `result`=17; a following DISPLAY r1 → 17. Hold `instr_valid` high throughout HOLD: exactly one acceptance, `instr_ready` low for 4 cycles.
- CLEAR after loading r0..r15 with nonzero values → `opcode`=110, `result`=0. DISPLAY of any register → 0.
- Assert `rst` on MUL cycle 8, with r1=3, r2=5 and prior r3=77 → next cycle `opcode`=000, `result`=0, `done`=0, `instr_ready`=0; one cycle later `instr_ready`=1; DISPLAY r3 → 0.
